// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART tx ready/valid port; ARB_TIMEOUT_EN adds stalled-owner release.
// Latency: 1 cycle req_valid->grant, then combinational pass-through; exactly 1 idle bubble between packets.
// Backpressure: tx_ready feeds straight to the owner's req_ready; every non-owner sees ready low.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1_250_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               release_now;
    logic               xfer;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign grant = grant_q;
    assign busy  = busy_q;

    // Downward scan so the candidate closest to rr_ptr wins.
    always_comb begin
        int cand;
        cand     = 0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req_valid[PTR_W'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        tx_data   = '0;
        tx_valid  = 1'b0;
        req_ready = '0;
        if (state_q == ST_LOCKED) begin
            tx_data           = req_data[{gidx_q, 3'b000} +: 8];
            tx_valid          = req_valid[gidx_q];
            req_ready[gidx_q] = tx_ready;
        end
    end

    assign xfer = tx_valid && tx_ready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_LOCKED;
                    gidx_d  = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                end
            end
            default: begin
                if (xfer && req_last[gidx_q]) begin
                    release_now = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (!req_valid[gidx_q]) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) release_now = 1'b1;
                    else                                     cnt_d = cnt_q + CNT_W'(1);
                end
`endif
                if (release_now) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
                end
            end
        endcase
        busy_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: owner/pointer model checked every cycle plus directed byte-stream expectations.
module tb_uart_tx_arbiter;
    localparam int NREQ = 2;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
    logic [7:0]        tx_data;
    logic              tx_valid, tx_ready, busy;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Requester drivers: each presents the head of its queue and pops it once accepted.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic took0, took1;

    assign req_valid = {v1, v0};
    assign req_last  = {l1, l0};
    assign req_data  = {d1, d0};

    initial forever begin
        @(negedge clk);
        took0 = v0 && req_ready[0] && rst_n;
        @(posedge clk);
        #1;
        if (took0) void'(q0.pop_front());
        if (q0.size() > 0) begin v0 = 1'b1; {l0, d0} = q0[0]; end
        else begin v0 = 1'b0; l0 = 1'b0; d0 = 8'h00; end
    end

    initial forever begin
        @(negedge clk);
        took1 = v1 && req_ready[1] && rst_n;
        @(posedge clk);
        #1;
        if (took1) void'(q1.pop_front());
        if (q1.size() > 0) begin v1 = 1'b1; {l1, d1} = q1[0]; end
        else begin v1 = 1'b0; l1 = 1'b0; d1 = 8'h00; end
    end

    // Model: who owns the port, whose turn is next, how long the owner has been silent.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_idle  = 0;

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int off = 0; off < NREQ; off++)
            if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_idle  <= 0;
        end else if (m_owner < 0) begin
            m_owner <= pick(req_valid, m_ptr);
            m_idle  <= 0;
        end else if (req_valid[m_owner] && tx_ready && req_last[m_owner]) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % NREQ;
        end
`ifdef ARB_TIMEOUT_EN
        else if (req_valid[m_owner]) m_idle <= 0;
        else if (m_idle == TMO - 1) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % NREQ;
            m_idle  <= 0;
        end else m_idle <= m_idle + 1;
`endif
    end

    function automatic int e_grant();
        return (m_owner < 0) ? 0 : (1 << m_owner);
    endfunction
    function automatic int e_valid();
        return (m_owner < 0) ? 0 : int'(req_valid[m_owner]);
    endfunction
    function automatic int e_data();
        return (m_owner < 0) ? 0 : int'(req_data[m_owner*8 +: 8]);
    endfunction
    function automatic int e_ready();
        return (m_owner < 0) ? 0 : (int'(tx_ready) << m_owner);
    endfunction

    always @(negedge clk) begin
        chk("grant", int'(grant), e_grant());
        chk("busy", int'(busy), int'(m_owner >= 0));
        chk("tx_valid", int'(tx_valid), e_valid());
        chk("tx_data", int'(tx_data), e_data());
        chk("req_ready", int'(req_ready), e_ready());
    end

    // Log of every byte the UART accepted.
    int out_d[$];
    int out_g[$];
    int out_c[$];
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            out_d.push_back(int'(tx_data));
            out_g.push_back(int'(grant));
            out_c.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("drain timeout", n, 0);
    endtask

    task automatic chk_out(input string nm, input int i, input int ed, input int eg);
        if (i >= out_d.size()) chk({nm, " missing"}, out_d.size(), i + 1);
        else begin
            chk(nm, out_d[i], ed);
            chk({nm, " grant"}, out_g[i], eg);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        out_d.delete();
        out_g.delete();
        out_c.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic pat [10];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst_n    = 1'b0;
        tx_ready = 1'b0;

        // Reset holds everything quiet even with both requesters valid.
        q0.push_back({1'b1, 8'hA5});
        q1.push_back({1'b1, 8'h5A});
        repeat (3) step();
        @(negedge clk);
        chk("rst grant", int'(grant), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst tx_valid", int'(tx_valid), 0);
        chk("rst req_ready", int'(req_ready), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("first grant", int'(grant), 1);
        tx_ready = 1'b1;
        wait_drain();
        step();
        chk_out("rst out0", 0, 8'hA5, 1);
        chk_out("rst out1", 1, 8'h5A, 2);

        // Single 3-byte packet from requester 1.
        do_reset();
        q1.push_back({1'b0, 8'h48});
        q1.push_back({1'b0, 8'h69});
        q1.push_back({1'b1, 8'h0A});
        wait_drain();
        @(negedge clk);
        chk("grant after last", int'(grant), 0);
        step();
        chk("single count", out_d.size(), 3);
        chk_out("single b0", 0, 8'h48, 2);
        chk_out("single b1", 1, 8'h69, 2);
        chk_out("single b2", 2, 8'h0A, 2);

        // Requester 1 arrives mid-packet; requester 0 keeps the port until its last byte.
        do_reset();
        for (int i = 0; i < 4; i++) q0.push_back({(i == 3), 8'(8'h10 + i)});
        step();
        step();
        q1.push_back({1'b1, 8'h20});
        wait_drain();
        step();
        step();
        for (int i = 0; i < 4; i++) chk_out("lock byte", i, 8'h10 + i, 1);
        chk_out("lock next", 4, 8'h20, 2);
        if (out_c.size() == 5) begin
            for (int i = 0; i < 3; i++) chk("lock contiguous", out_c[i+1] - out_c[i], 1);
            chk("lock bubble", out_c[4] - out_c[3], 2);
        end else chk("lock count", out_c.size(), 5);

        // Both continuously valid with single-byte packets: strict alternation from requester 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 8'hA0});
            q1.push_back({1'b1, 8'hB1});
        end
        wait_drain();
        step();
        step();
        chk("rr count", out_d.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_out("rr byte", i, (i % 2 == 0) ? 8'hA0 : 8'hB1, (i % 2 == 0) ? 1 : 2);

        // Backpressure: each byte goes out once, in order, despite stalls.
        do_reset();
        tx_ready = 1'b0;
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h22});
        q0.push_back({1'b1, 8'h33});
        for (int i = 0; i < 10; i++) begin
            tx_ready = pat[i];
            step();
        end
        tx_ready = 1'b1;
        wait_drain();
        step();
        step();
        chk("bp count", out_d.size(), 3);
        chk_out("bp b0", 0, 8'h11, 1);
        chk_out("bp b1", 1, 8'h22, 1);
        chk_out("bp b2", 2, 8'h33, 1);

        // Owner stalls mid-packet while requester 1 waits.
        do_reset();
        q0.push_back({1'b0, 8'h55});
        repeat (4) step();
        q1.push_back({1'b1, 8'h77});
`ifdef ARB_TIMEOUT_EN
        wait_drain();
        step();
        step();
        chk("tmo count", out_d.size(), 2);
        chk_out("tmo b0", 0, 8'h55, 1);
        chk_out("tmo b1", 1, 8'h77, 2);
        if (out_c.size() == 2) chk("tmo gap", out_c[1] - out_c[0], 18);
`else
        repeat (30) step();
        @(negedge clk);
        chk("stall grant held", int'(grant), 1);
        chk("stall count", out_d.size(), 1);
        q0.push_back({1'b1, 8'h56});
        wait_drain();
        step();
        step();
        chk_out("stall b0", 0, 8'h55, 1);
        chk_out("stall b1", 1, 8'h56, 1);
        chk_out("stall b2", 2, 8'h77, 2);
`endif

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
